// File: rtl/dmux_stream.sv
// Registered valid/ready demultiplexer: routes one WIDTH-bit word to one of CHANNELS
// one-entry output registers. Optional broadcast mode under `DMUX_STREAM_BROADCAST_EN.
module dmux_stream #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  localparam int SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic [WIDTH-1:0]          in_data_i,
  input  logic [SEL_W-1:0]          in_sel_i,
  input  logic                      in_valid_i,
  input  logic                      in_bcast_i,
  output logic                      in_ready_o,
  output logic [CHANNELS*WIDTH-1:0] out_data_o,
  output logic [CHANNELS-1:0]       out_valid_o,
  input  logic [CHANNELS-1:0]       out_ready_i,
  output logic [7:0]                err_cnt_o
);

  localparam logic [SEL_W:0] CH_LIMIT = (SEL_W+1)'(CHANNELS);
  localparam logic [7:0]     ERR_MAX  = 8'hFF;

  logic [WIDTH-1:0]    data_q [CHANNELS];
  logic [WIDTH-1:0]    data_d [CHANNELS];
  logic [CHANNELS-1:0] valid_q, valid_d;
  logic [7:0]          err_q, err_d;

  logic [CHANNELS-1:0] drain_w, free_w, sel_onehot, load_w;
  logic                sel_in_range, free_sel, bcast_w, accept_w, drop_w;

`ifdef DMUX_STREAM_BROADCAST_EN
  assign bcast_w = in_bcast_i;
`else
  // Broadcast port kept for identical connectivity; folded to a constant 0.
  assign bcast_w = in_bcast_i & 1'b0;
`endif

  assign drain_w      = valid_q & out_ready_i;
  assign free_w       = ~valid_q | drain_w;
  assign sel_in_range = ({1'b0, in_sel_i} < CH_LIMIT);

  // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
  always_comb begin
    sel_onehot = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      sel_onehot[k] = (in_sel_i == SEL_W'(k));
    end
  end

  assign free_sel = |(sel_onehot & free_w);

  // Ready never looks at in_valid_i, so the producer can safely wait on it.
  always_comb begin
    in_ready_o = 1'b1;
    if (bcast_w) begin
      in_ready_o = &free_w;
    end else if (sel_in_range) begin
      in_ready_o = free_sel;
    end
  end

  assign accept_w = in_valid_i & in_ready_o;
  assign drop_w   = accept_w & ~bcast_w & ~sel_in_range;

  always_comb begin
    load_w = '0;
    if (accept_w) begin
      if (bcast_w) begin
        load_w = '1;
      end else if (sel_in_range) begin
        load_w = sel_onehot;
      end
    end
  end

  // Refill wins over drain, giving one word per cycle per channel.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    for (int k = 0; k < CHANNELS; k++) begin
      if (load_w[k]) begin
        data_d[k]  = in_data_i;
        valid_d[k] = 1'b1;
      end else if (drain_w[k]) begin
        data_d[k]  = '0;
        valid_d[k] = 1'b0;
      end
    end
  end

  always_comb begin
    err_d = err_q;
    if (drop_w && (err_q != ERR_MAX)) begin
      err_d = err_q + 8'd1;
    end
  end

  // NOTE: the data registers are reset too, because unselected channels must read zero.
  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      data_q  <= '{default: '0};
      valid_q <= '0;
      err_q   <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    out_data_o = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      out_data_o[k*WIDTH +: WIDTH] = data_q[k];
    end
  end

  assign out_valid_o = valid_q;
  assign err_cnt_o   = err_q;

endmodule

// File: tb/tb_dmux_stream.sv
// Scoreboard bench for dmux_stream: a 4-channel instance for routing/handshake checks and
// a 3-channel instance for out-of-range select and error-counter saturation.
module tb_dmux_stream;

  localparam int W = 16;

  logic clk_i = 1'b0;
  logic rst_n_i;
  always #5 clk_i = ~clk_i;

  logic [W-1:0]   in_data;
  logic [1:0]     in_sel;
  logic           in_valid, in_bcast, in_ready;
  logic [4*W-1:0] out_data;
  logic [3:0]     out_valid, out_ready;
  logic [7:0]     err_cnt;

  logic [W-1:0]   d3_in_data;
  logic [1:0]     d3_in_sel;
  logic           d3_in_valid, d3_in_bcast, d3_in_ready;
  logic [3*W-1:0] d3_out_data;
  logic [2:0]     d3_out_valid, d3_out_ready;
  logic [7:0]     d3_err_cnt;

  dmux_stream #(.WIDTH(W), .CHANNELS(4)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .in_data_i(in_data), .in_sel_i(in_sel), .in_valid_i(in_valid), .in_bcast_i(in_bcast),
    .in_ready_o(in_ready), .out_data_o(out_data), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .err_cnt_o(err_cnt)
  );

  dmux_stream #(.WIDTH(W), .CHANNELS(3)) dut3 (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .in_data_i(d3_in_data), .in_sel_i(d3_in_sel), .in_valid_i(d3_in_valid),
    .in_bcast_i(d3_in_bcast), .in_ready_o(d3_in_ready), .out_data_o(d3_out_data),
    .out_valid_o(d3_out_valid), .out_ready_i(d3_out_ready), .err_cnt_o(d3_err_cnt)
  );

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;
  logic [W-1:0] exp_q [4][$];

  function automatic logic [W-1:0] chan(input int k);
    return out_data[k*W +: W];
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Delivery monitor: each drained word is popped from its channel's queue and compared;
  // idle channels must read zero.
  always @(negedge clk_i) begin
    if (mon_en && rst_n_i) begin
      for (int k = 0; k < 4; k++) begin
        if (out_valid[k] && out_ready[k]) begin
          total++;
          if (exp_q[k].size() == 0) begin
            bad++;
            $display("FAIL deliver_ch%0d unexpected word got=%h want=none", k, chan(k));
          end else begin
            logic [W-1:0] e;
            e = exp_q[k].pop_front();
            if (chan(k) !== e) begin
              bad++;
              $display("FAIL deliver_ch%0d got=%h want=%h", k, chan(k), e);
            end
          end
        end else if (!out_valid[k]) begin
          total++;
          if (chan(k) !== '0) begin
            bad++;
            $display("FAIL idle_zero_ch%0d got=%h want=0000", k, chan(k));
          end
        end
      end
    end
  end

  task automatic test_reset();
    #2;
    total++; if (out_valid !== 4'b0000) begin bad++; $display("FAIL rst_valid got=%b want=0000", out_valid); end
    total++; if (out_data !== '0) begin bad++; $display("FAIL rst_data got=%h want=0", out_data); end
    total++; if (err_cnt !== 8'h00) begin bad++; $display("FAIL rst_err got=%h want=00", err_cnt); end
    total++; if (d3_err_cnt !== 8'h00) begin bad++; $display("FAIL rst_err3 got=%h want=00", d3_err_cnt); end
    @(negedge clk_i);
    rst_n_i   = 1'b1;
    out_ready = 4'b1011;
    in_data   = 16'hBEEF;
    in_sel    = 2'd2;
    in_valid  = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_first_ready got=%b want=1", in_ready); end
    tick();
    in_valid = 1'b0;
    @(negedge clk_i);
    total++; if (out_valid !== 4'b0100) begin bad++; $display("FAIL rst_fill_valid got=%b want=0100", out_valid); end
    total++; if (chan(2) !== 16'hBEEF) begin bad++; $display("FAIL rst_fill_data got=%h want=beef", chan(2)); end
    #2;
    rst_n_i = 1'b0;
    #1;
    total++; if (out_valid !== 4'b0000) begin bad++; $display("FAIL rst_mid_valid got=%b want=0000", out_valid); end
    total++; if (out_data !== '0) begin bad++; $display("FAIL rst_mid_data got=%h want=0", out_data); end
    total++; if (err_cnt !== 8'h00) begin bad++; $display("FAIL rst_mid_err got=%h want=00", err_cnt); end
    #1;
    rst_n_i = 1'b1;
    tick();
    mon_en = 1'b1;
  endtask

  task automatic test_single_route();
    out_ready = 4'hF;
    in_data = 16'h1234; in_sel = 2'd1; in_valid = 1'b1;
    @(negedge clk_i);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL route_ready got=%b want=1", in_ready); end
    exp_q[1].push_back(16'h1234);
    tick();
    in_valid = 1'b0;
    @(negedge clk_i);
    total++; if (out_valid !== 4'b0010) begin bad++; $display("FAIL route_valid got=%b want=0010", out_valid); end
    total++; if (out_data !== {16'h0, 16'h0, 16'h1234, 16'h0}) begin bad++; $display("FAIL route_data got=%h want=0000000012340000", out_data); end
    tick();
    @(negedge clk_i);
    total++; if (out_valid !== 4'b0000) begin bad++; $display("FAIL route_empty_valid got=%b want=0000", out_valid); end
    total++; if (out_data !== '0) begin bad++; $display("FAIL route_empty_data got=%h want=0", out_data); end
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 4'b0111;
    in_data = 16'hAAAA; in_sel = 2'd3; in_valid = 1'b1;
    @(negedge clk_i);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_first_ready got=%b want=1", in_ready); end
    exp_q[3].push_back(16'hAAAA);
    tick();
    in_data = 16'hBBBB;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk_i);
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_stall_ready c%0d got=%b want=0", c, in_ready); end
      total++; if (chan(3) !== 16'hAAAA) begin bad++; $display("FAIL bp_hold_data c%0d got=%h want=aaaa", c, chan(3)); end
      total++; if (out_valid !== 4'b1000) begin bad++; $display("FAIL bp_hold_valid c%0d got=%b want=1000", c, out_valid); end
      tick();
    end
    out_ready = 4'hF;
    @(negedge clk_i);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b want=1", in_ready); end
    exp_q[3].push_back(16'hBBBB);
    tick();
    in_valid = 1'b0;
    @(negedge clk_i);
    total++; if (chan(3) !== 16'hBBBB) begin bad++; $display("FAIL bp_second_data got=%h want=bbbb", chan(3)); end
    total++; if (out_valid !== 4'b1000) begin bad++; $display("FAIL bp_second_valid got=%b want=1000", out_valid); end
    tick();
    @(negedge clk_i);
    total++; if (out_valid !== 4'b0000) begin bad++; $display("FAIL bp_empty got=%b want=0000", out_valid); end
    tick();
  endtask

  task automatic test_back_to_back();
    out_ready = 4'hF;
    in_sel = 2'd0; in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = W'(i);
      @(negedge clk_i);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_ready i%0d got=%b want=1", i, in_ready); end
      if (i > 0) begin
        total++; if (chan(0) !== W'(i - 1)) begin bad++; $display("FAIL stream_data i%0d got=%h want=%h", i, chan(0), W'(i - 1)); end
      end
      exp_q[0].push_back(W'(i));
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk_i);
    total++; if (chan(0) !== 16'h0007) begin bad++; $display("FAIL stream_last got=%h want=0007", chan(0)); end
    tick();
  endtask

  task automatic test_out_of_range();
    int rdy_bad = 0;
    int vld_bad = 0;
    d3_out_ready = 3'b111;
    d3_in_data = 16'hFFFF; d3_in_sel = 2'd3; d3_in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_i);
      if (d3_in_ready !== 1'b1) rdy_bad++;
      if (d3_out_valid !== 3'b000) vld_bad++;
      if (i == 5) begin
        total++; if (d3_err_cnt !== 8'd5) begin bad++; $display("FAIL oor_err5 got=%h want=05", d3_err_cnt); end
      end
      if (i == 255) begin
        total++; if (d3_err_cnt !== 8'hFF) begin bad++; $display("FAIL oor_err255 got=%h want=ff", d3_err_cnt); end
      end
      tick();
    end
    total++; if (rdy_bad !== 0) begin bad++; $display("FAIL oor_ready stalled_cycles got=%0d want=0", rdy_bad); end
    total++; if (vld_bad !== 0) begin bad++; $display("FAIL oor_no_valid valid_cycles got=%0d want=0", vld_bad); end
    total++; if (d3_err_cnt !== 8'hFF) begin bad++; $display("FAIL oor_sat got=%h want=ff", d3_err_cnt); end
    d3_in_data = 16'h3333; d3_in_sel = 2'd2;
    tick();
    d3_in_valid = 1'b0;
    @(negedge clk_i);
    total++; if (d3_out_valid !== 3'b100) begin bad++; $display("FAIL oor_top_valid got=%b want=100", d3_out_valid); end
    total++; if (d3_out_data !== {16'h3333, 16'h0, 16'h0}) begin bad++; $display("FAIL oor_top_data got=%h want=333300000000", d3_out_data); end
    total++; if (d3_err_cnt !== 8'hFF) begin bad++; $display("FAIL oor_hold got=%h want=ff", d3_err_cnt); end
    tick();
  endtask

  task automatic test_broadcast();
    out_ready = 4'b1011;
    in_data = 16'h1111; in_sel = 2'd2; in_bcast = 1'b0; in_valid = 1'b1;
    @(negedge clk_i);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bc_fill_ready got=%b want=1", in_ready); end
    exp_q[2].push_back(16'h1111);
    tick();
    in_data = 16'h5A5A; in_sel = 2'd0; in_bcast = 1'b1;
`ifdef DMUX_STREAM_BROADCAST_EN
    for (int c = 0; c < 2; c++) begin
      @(negedge clk_i);
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bc_stall_ready c%0d got=%b want=0", c, in_ready); end
      total++; if (chan(2) !== 16'h1111) begin bad++; $display("FAIL bc_stall_hold c%0d got=%h want=1111", c, chan(2)); end
      tick();
    end
    out_ready = 4'hF;
    @(negedge clk_i);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bc_release_ready got=%b want=1", in_ready); end
    for (int k = 0; k < 4; k++) exp_q[k].push_back(16'h5A5A);
    tick();
    in_valid = 1'b0; in_bcast = 1'b0;
    @(negedge clk_i);
    total++; if (out_valid !== 4'hF) begin bad++; $display("FAIL bc_all_valid got=%b want=1111", out_valid); end
    total++; if (out_data !== {4{16'h5A5A}}) begin bad++; $display("FAIL bc_all_data got=%h want=5a5a5a5a5a5a5a5a", out_data); end
    tick();
`else
    @(negedge clk_i);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bc_off_ready got=%b want=1", in_ready); end
    exp_q[0].push_back(16'h5A5A);
    tick();
    in_valid = 1'b0; in_bcast = 1'b0;
    @(negedge clk_i);
    total++; if (out_valid !== 4'b0101) begin bad++; $display("FAIL bc_off_valid got=%b want=0101", out_valid); end
    total++; if (out_data !== {16'h0, 16'h1111, 16'h0, 16'h5A5A}) begin bad++; $display("FAIL bc_off_data got=%h want=0000111100005a5a", out_data); end
    tick();
    out_ready = 4'hF;
    @(negedge clk_i);
    total++; if (out_valid !== 4'b0100) begin bad++; $display("FAIL bc_off_drain got=%b want=0100", out_valid); end
    tick();
`endif
    @(negedge clk_i);
    total++; if (out_valid !== 4'b0000) begin bad++; $display("FAIL bc_empty got=%b want=0000", out_valid); end
    total++; if (err_cnt !== 8'h00) begin bad++; $display("FAIL bc_err got=%h want=00", err_cnt); end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n_i = 1'b0;
    in_data = '0; in_sel = '0; in_valid = 1'b0; in_bcast = 1'b0; out_ready = '0;
    d3_in_data = '0; d3_in_sel = '0; d3_in_valid = 1'b0; d3_in_bcast = 1'b0; d3_out_ready = '0;
    test_reset();
    test_single_route();
    test_backpressure();
    test_back_to_back();
    test_out_of_range();
    test_broadcast();
    for (int k = 0; k < 4; k++) begin
      total++;
      if (exp_q[k].size() != 0) begin
        bad++;
        $display("FAIL undelivered_ch%0d got=%0d words want=0", k, exp_q[k].size());
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
